// File: rtl/rv32i_seq_pkg.sv
// Shared state, select and trap-cause types plus RV32I opcode constants
// for the multicycle sequencer.
package rv32i_seq_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        TC_NONE        = 2'd0,
        TC_ILLEGAL     = 2'd1,
        TC_MEM_TIMEOUT = 2'd2
    } trap_cause_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
            default:                            is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_seq_wait_timer.sv
// Memory wait counter: counts consecutive stalled request cycles and flags
// the cycle in which the access has exhausted its MEM_TIMEOUT budget.
module rv32i_seq_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req,
    input  logic i_ready,
    output logic o_timeout
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall;

    assign w_stall = i_req && !i_ready;

    // Any non-stalled cycle (idle or completed transfer) restarts the count,
    // so every FETCH/MEM entry and every transfer begins from zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_timeout = w_stall && (r_cnt == LAST);

endmodule

// File: rtl/rv32i_mc_sequencer.sv
// Multicycle control FSM for the RV32I core with shared memory port.
// Optional performance counters are enabled by defining RV_SEQ_PERF_CNT_EN.
module rv32i_mc_sequencer
    import rv32i_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [6:0]        opcode,
    input  logic              branch_cond,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addr_sel,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              alu_b_sel,
    output logic              reg_write,
    output logic [1:0]        wb_sel,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [2:0]        state_o
`ifdef RV_SEQ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    state_e      r_state;
    state_e      w_next;
    logic        r_trap;
    trap_cause_e r_cause;
    trap_cause_e w_cause;
    logic        w_mem_phase;
    logic        w_timeout;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_b_imm;

    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (opcode == OP_STORE);
    assign w_b_imm    = !((opcode == OP_R) || (opcode == OP_BRANCH));

    // Request decoded from state alone so the timer path stays loop-free.
    assign w_mem_phase = reset_n && ((r_state == FETCH) || (r_state == MEM));
    assign mem_req     = w_mem_phase;

    rv32i_seq_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (w_mem_phase),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= FETCH;
            r_trap  <= 1'b0;
            r_cause <= TC_NONE;
        end else begin
            r_state <= w_next;
            if ((w_next == TRAP) && (r_state != TRAP)) begin
                r_trap  <= 1'b1;
                r_cause <= w_cause;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cause      = TC_NONE;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        alu_b_sel    = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        case (r_state)
            FETCH: begin
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = DECODE;
                end else if (w_timeout) begin
                    w_next  = TRAP;
                    w_cause = TC_MEM_TIMEOUT;
                end
            end
            DECODE: begin
                if (is_legal_op(opcode)) begin
                    w_next = EXECUTE;
                end else begin
                    w_next  = TRAP;
                    w_cause = TC_ILLEGAL;
                end
            end
            EXECUTE: begin
                alu_b_sel = w_b_imm;
                w_next    = FETCH;
                case (opcode)
                    OP_BRANCH: begin
                        pc_write = branch_cond;
                        pc_src   = PC_BRANCH;
                    end
                    OP_JAL, OP_JALR: begin
                        pc_write  = 1'b1;
                        pc_src    = (opcode == OP_JALR) ? PC_JALR : PC_BRANCH;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                    end
                    OP_LOAD, OP_STORE: w_next = MEM;
                    default:           w_next = WB;
                endcase
            end
            MEM: begin
                // Operand select held so the address survives without an ALU-out latch.
                alu_b_sel    = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = w_is_store;
                if (mem_ready) begin
                    w_next = w_is_load ? WB : FETCH;
                end else if (w_timeout) begin
                    w_next  = TRAP;
                    w_cause = TC_MEM_TIMEOUT;
                end
            end
            WB: begin
                alu_b_sel = w_b_imm;
                reg_write = 1'b1;
                wb_sel    = w_is_load ? WB_MEM : WB_ALU;
                w_next    = FETCH;
            end
            default: w_next = TRAP;
        endcase
        if (!reset_n) begin
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = PC_PLUS4;
            alu_b_sel    = 1'b0;
            reg_write    = 1'b0;
            wb_sel       = WB_ALU;
        end
    end

    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign state_o    = r_state;

`ifdef RV_SEQ_PERF_CNT_EN
    logic [PERF_W-1:0] r_cycle_cnt;
    logic [PERF_W-1:0] r_instret_cnt;
    logic              w_retire;

    assign w_retire = ((r_state == EXECUTE) || (r_state == MEM) || (r_state == WB))
                      && (w_next == FETCH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != TRAP) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// Self-checking bench for rv32i_mc_sequencer: directed scenarios plus
// randomized instruction streams checked against a per-instruction phase model.
`timescale 1ns/1ps
module tb_rv32i_mc_sequencer;

    localparam int unsigned TO = 4;
    localparam int unsigned PW = 4;

    localparam logic [6:0] C_R      = 7'b0110011;
    localparam logic [6:0] C_I      = 7'b0010011;
    localparam logic [6:0] C_LOAD   = 7'b0000011;
    localparam logic [6:0] C_STORE  = 7'b0100011;
    localparam logic [6:0] C_BRANCH = 7'b1100011;
    localparam logic [6:0] C_JAL    = 7'b1101111;
    localparam logic [6:0] C_JALR   = 7'b1100111;
    localparam logic [6:0] C_LUI    = 7'b0110111;
    localparam logic [6:0] C_AUIPC  = 7'b0010111;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DEC   = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_TRAP  = 3'd5;

    logic          clk;
    logic          reset_n;
    logic [6:0]    opcode;
    logic          branch_cond;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic          mem_addr_sel;
    logic          ir_write;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          alu_b_sel;
    logic          reg_write;
    logic [1:0]    wb_sel;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [2:0]    state_o;
`ifdef RV_SEQ_PERF_CNT_EN
    logic [PW-1:0] cycle_cnt;
    logic [PW-1:0] instret_cnt;
`endif

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned m_cycles;
    int unsigned m_instret;
    bit          m_trap;
    logic [6:0]  legal_ops [9];

    rv32i_mc_sequencer #(
        .MEM_TIMEOUT (TO),
        .PERF_W      (PW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .branch_cond  (branch_cond),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_b_sel    (alu_b_sel),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .state_o      (state_o)
`ifdef RV_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        legal = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (legal_ops[i] == op) legal = 1'b1;
        end
    endfunction

    // One clock; the model counts non-trap cycles and clears on reset edges.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            m_cycles  = 0;
            m_instret = 0;
            m_trap    = 1'b0;
        end else if (!m_trap) begin
            m_cycles++;
        end
        #1;
    endtask

    task automatic chk_perf(input string tag);
`ifdef RV_SEQ_PERF_CNT_EN
        check_eq({tag, ".cycle_cnt"}, 32'(cycle_cnt), m_cycles % (1 << PW));
        check_eq({tag, ".instret_cnt"}, 32'(instret_cnt), m_instret % (1 << PW));
`else
        check_eq({tag, ".no_trap"}, 32'(trap), 32'(m_trap));
`endif
    endtask

    task automatic chk_phase(input string tag, input logic [2:0] e_st, input logic e_req,
                             input logic e_we, input logic e_asel, input logic e_irw,
                             input logic e_pcw, input logic [1:0] e_src, input logic e_rw,
                             input logic [1:0] e_wbs, input logic chk_b, input logic e_b);
        check_eq({tag, ".state"}, 32'(state_o), 32'(e_st));
        check_eq({tag, ".mem_req"}, 32'(mem_req), 32'(e_req));
        if (e_req) begin
            check_eq({tag, ".mem_we"}, 32'(mem_we), 32'(e_we));
            check_eq({tag, ".mem_addr_sel"}, 32'(mem_addr_sel), 32'(e_asel));
        end
        check_eq({tag, ".ir_write"}, 32'(ir_write), 32'(e_irw));
        check_eq({tag, ".pc_write"}, 32'(pc_write), 32'(e_pcw));
        if (e_pcw) check_eq({tag, ".pc_src"}, 32'(pc_src), 32'(e_src));
        check_eq({tag, ".reg_write"}, 32'(reg_write), 32'(e_rw));
        if (e_rw) check_eq({tag, ".wb_sel"}, 32'(wb_sel), 32'(e_wbs));
        if (chk_b) check_eq({tag, ".alu_b_sel"}, 32'(alu_b_sel), 32'(e_b));
        check_eq({tag, ".trap"}, 32'(trap), 32'(0));
    endtask

    task automatic chk_trap(input string tag, input logic [1:0] e_cause);
        check_eq({tag, ".state"}, 32'(state_o), 32'(S_TRAP));
        check_eq({tag, ".trap"}, 32'(trap), 32'(1));
        check_eq({tag, ".cause"}, 32'(trap_cause), 32'(e_cause));
        check_eq({tag, ".enables"},
                 32'({mem_req, mem_we, ir_write, pc_write, reg_write}), 32'(0));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_ready = 1'($urandom);
        tick();
        #1;
        check_eq("rst.state", 32'(state_o), 32'(S_FETCH));
        check_eq("rst.trap", 32'({trap, trap_cause}), 32'(0));
        check_eq("rst.enables",
                 32'({mem_req, mem_we, ir_write, pc_write, reg_write}), 32'(0));
        chk_perf("rst");
        reset_n = 1'b1;
    endtask

    // Drives one instruction through its phases and checks every cycle.
    task automatic run_instr(input logic [6:0] op, input logic bc, input int unsigned fw,
                             input int unsigned mw, input bit stall_mem);
        bit          is_ld, is_st, is_br, is_j, is_jr, is_r, to_wb, e_pcw;
        logic [1:0]  e_src;
        int unsigned cyc, exp_cyc;
        is_ld = (op == C_LOAD);
        is_st = (op == C_STORE);
        is_br = (op == C_BRANCH);
        is_j  = (op == C_JAL);
        is_jr = (op == C_JALR);
        is_r  = (op == C_R);
        to_wb = is_ld || is_r || (op == C_I) || (op == C_LUI) || (op == C_AUIPC);
        cyc   = 0;
        opcode = op;
        for (int unsigned w = 0; w <= fw; w++) begin
            mem_ready   = (w == fw);
            branch_cond = 1'($urandom);
            #2;
            chk_phase("fetch", S_FETCH, 1'b1, 1'b0, 1'b0, w == fw, w == fw, 2'd0,
                      1'b0, 2'd0, 1'b0, 1'b0);
            tick();
            cyc++;
        end
        mem_ready = 1'($urandom);
        #2;
        chk_phase("decode", S_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        cyc++;
        branch_cond = bc;
        mem_ready   = 1'($urandom);
        e_pcw = is_br ? bc : (is_j || is_jr);
        e_src = is_jr ? 2'd2 : 2'd1;
        #2;
        chk_phase("exec", S_EXE, 1'b0, 1'b0, 1'b0, 1'b0, e_pcw, e_src, is_j || is_jr, 2'd2,
                  1'b1, !(is_r || is_br));
        tick();
        cyc++;
        if (is_ld || is_st) begin
            if (stall_mem) begin
                for (int unsigned w = 0; w < TO; w++) begin
                    mem_ready = 1'b0;
                    #2;
                    chk_phase("mem_stall", S_MEM, 1'b1, is_st, 1'b1, 1'b0, 1'b0, 2'd0,
                              1'b0, 2'd0, 1'b0, 1'b0);
                    tick();
                end
                m_trap = 1'b1;
                #2;
                chk_trap("mem_timeout", 2'd2);
                chk_perf("mem_timeout");
                do_reset();
                return;
            end
            for (int unsigned w = 0; w <= mw; w++) begin
                mem_ready   = (w == mw);
                branch_cond = 1'($urandom);
                #2;
                chk_phase("mem", S_MEM, 1'b1, is_st, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0,
                          1'b0, 1'b0);
                tick();
                cyc++;
            end
        end
        if (to_wb) begin
            mem_ready = 1'($urandom);
            #2;
            chk_phase("wb", S_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1,
                      is_ld ? 2'd1 : 2'd0, 1'b0, 1'b0);
            tick();
            cyc++;
        end
        m_instret++;
        exp_cyc = (is_br || is_j || is_jr) ? 3 : (is_ld ? 5 : 4);
        exp_cyc += fw + ((is_ld || is_st) ? mw : 0);
        check_eq("cpi", cyc, exp_cyc);
        #1;
        check_eq("retire.state", 32'(state_o), 32'(S_FETCH));
        chk_perf("retire");
    endtask

    task automatic run_illegal(input logic [6:0] op, input int unsigned n);
        opcode    = op;
        mem_ready = 1'b1;
        #2;
        chk_phase("ill_fetch", S_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0,
                  1'b0, 1'b0);
        tick();
        mem_ready = 1'($urandom);
        #2;
        chk_phase("ill_decode", S_DEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0,
                  1'b0, 1'b0);
        tick();
        m_trap = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            mem_ready   = 1'($urandom);
            branch_cond = 1'($urandom);
            #2;
            chk_trap("illegal", 2'd1);
            tick();
        end
        chk_perf("illegal");
        do_reset();
    endtask

    task automatic fetch_timeout();
        opcode = C_R;
        for (int unsigned i = 0; i < TO; i++) begin
            mem_ready = 1'b0;
            #2;
            chk_phase("fetch_stall", S_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0,
                      1'b0, 1'b0);
            tick();
        end
        m_trap = 1'b1;
        #2;
        chk_trap("fetch_timeout", 2'd2);
        chk_perf("fetch_timeout");
        do_reset();
    endtask

    initial begin
        logic [6:0]  ill;
        int unsigned r;
        logic [6:0]  op;
        n_checks     = 0;
        n_fail       = 0;
        m_cycles     = 0;
        m_instret    = 0;
        m_trap       = 1'b0;
        legal_ops    = '{C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC};
        reset_n      = 1'b0;
        opcode       = C_R;
        branch_cond  = 1'b0;
        mem_ready    = 1'b0;
        do_reset();

        repeat (5) run_instr(C_R, 1'b0, 0, 0, 1'b0);
`ifdef RV_SEQ_PERF_CNT_EN
        check_eq("instret_after_5", 32'(instret_cnt), 32'(5));
`endif
        repeat (11) run_instr(C_R, 1'b0, 0, 0, 1'b0);
`ifdef RV_SEQ_PERF_CNT_EN
        check_eq("instret_wrap_16", 32'(instret_cnt), 32'(0));
`endif
        run_instr(C_LOAD, 1'b0, 0, 3, 1'b0);
        run_instr(C_BRANCH, 1'b1, 0, 0, 1'b0);
        run_instr(C_BRANCH, 1'b0, 0, 0, 1'b0);
        run_instr(C_JAL, 1'b0, 1, 0, 1'b0);
        run_instr(C_JALR, 1'b1, 0, 0, 1'b0);
        run_instr(C_STORE, 1'b0, 0, 2, 1'b0);
        run_illegal(7'b1111111, 20);
        fetch_timeout();
        run_instr(C_R, 1'b0, TO - 1, 0, 1'b0);
        run_instr(C_LOAD, 1'b0, 0, TO - 1, 1'b0);
        run_instr(C_STORE, 1'b0, 0, 0, 1'b1);

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 24);
            if (r == 0) begin
                do ill = 7'($urandom); while (legal(ill));
                run_illegal(ill, $urandom_range(1, 5));
            end else if (r == 1) begin
                fetch_timeout();
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
                run_instr(op, 1'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                          (r == 2) && ((op == C_LOAD) || (op == C_STORE)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
